// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums cfg_len PE partial sums, saturates each result
// to OUT_WIDTH, and queues it in a small FIFO drained over valid/ready.
module psum_accum #(
  parameter int IN_WIDTH   = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic [IN_WIDTH-1:0]  i_psum,
  input  logic                 i_psum_val,
  output logic [OUT_WIDTH-1:0] o_res,
  output logic                 o_res_val,
  input  logic                 i_res_rdy,
  output logic                 o_res_sat,
  output logic                 o_busy,
  output logic                 o_ovf
);

  // state | meaning
  // IDLE  | waiting for the first psum of a new result
  // ACC   | accumulating; cnt psums already summed into acc
  typedef enum logic {IDLE, ACC} state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'({OUT_WIDTH{1'b1}});

  state_t               state;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] len_eff;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum;
  logic                 push;
  logic                 sum_sat;
  logic [OUT_WIDTH-1:0] sum_res;

  logic [OUT_WIDTH-1:0] res_mem [FIFO_DEPTH];
  logic                 sat_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_FW-1:0]    count;
  logic                 pop;
  logic                 full;
  logic                 wr_en;

  always_comb begin
    len_eff = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
    sum     = (state == ACC) ? acc + ACC_WIDTH'(i_psum) : ACC_WIDTH'(i_psum);
    push    = 1'b0;
    if (i_psum_val) begin
      if (state == IDLE) push = (len_eff == CNT_WIDTH'(1));
      else               push = ((cnt + CNT_WIDTH'(1)) == len_q);
    end
    sum_sat = (sum > OUT_MAX);
    sum_res = sum_sat ? {OUT_WIDTH{1'b1}} : sum[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_psum_val) begin
            len_q <= len_eff;
            if (push) begin
              acc <= '0;
              cnt <= '0;
            end else begin
              acc   <= sum;
              cnt   <= CNT_WIDTH'(1);
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (i_psum_val) begin
            if (push) begin
              acc   <= '0;
              cnt   <= '0;
              state <= IDLE;
            end else begin
              acc <= sum;
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pop   = o_res_val && i_res_rdy;
  assign full  = (count == CNT_FW'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      res_mem <= '{default: '0};
      sat_mem <= '{default: 1'b0};
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_ovf   <= 1'b0;
    end else begin
      if (wr_en) begin
        res_mem[wr_ptr] <= sum_res;
        sat_mem[wr_ptr] <= sum_sat;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop)      count <= count + CNT_FW'(1);
      else if (!wr_en && pop) count <= count - CNT_FW'(1);
      if (push && full && !pop) o_ovf <= 1'b1;
    end
  end

  assign o_res     = res_mem[rd_ptr];
  assign o_res_sat = sat_mem[rd_ptr];
  assign o_res_val = (count != '0);
  assign o_busy    = (state == ACC);

endmodule

// File: tb/tb_psum_accum.sv
// Scoreboard bench for psum_accum: expected results are queued as psums are
// driven and checked as the DUT hands them downstream.
module tb_psum_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cfg_len;
  logic [7:0]  i_psum;
  logic        i_psum_val;
  logic [7:0]  o_res;
  logic        o_res_val;
  logic        i_res_rdy;
  logic        o_res_sat;
  logic        o_busy;
  logic        o_ovf;

  typedef struct { logic [7:0] res; logic sat; } exp_t;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  psum_accum dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .i_psum(i_psum),
    .i_psum_val(i_psum_val), .o_res(o_res), .o_res_val(o_res_val),
    .i_res_rdy(i_res_rdy), .o_res_sat(o_res_sat), .o_busy(o_busy), .o_ovf(o_ovf)
  );

  // Scoreboard: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && o_res_val === 1'b1 && i_res_rdy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got res=%0d sat=%0d, required no output", o_res, o_res_sat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_res !== e.res || o_res_sat !== e.sat) begin
          errors++;
          $display("FAIL result: got res=%0d sat=%0d, required res=%0d sat=%0d",
                   o_res, o_res_sat, e.res, e.sat);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v);
    i_psum = v; i_psum_val = 1'b1;
    cycle();
    i_psum_val = 1'b0;
  endtask

  task automatic expect_res(input logic [7:0] r, input logic s);
    exp_t e;
    e.res = r; e.sat = s;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (o_res !== 8'd0 || o_res_val !== 1'b0 || o_res_sat !== 1'b0 || o_busy !== 1'b0 || o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s: got res=%0d val=%b sat=%b busy=%b ovf=%b, required all 0",
               name, o_res, o_res_val, o_res_sat, o_busy, o_ovf);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_psum_val = 1'b0; i_psum = '0; cfg_len = '0; i_res_rdy = 1'b1;
    repeat (2) cycle();
    check_zero_outputs("reset_during");
    rst = 1'b0;
    cycle();
    check_zero_outputs("reset_after");
  endtask

  task automatic test_basic();
    logic [7:0] vals [3] = '{8'd10, 8'd20, 8'd30};
    cfg_len = 12'd3; i_res_rdy = 1'b1;
    expect_res(8'd60, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(vals[i]);
      checks++;
      if (o_busy !== (i < 2)) begin
        errors++;
        $display("FAIL basic_busy[%0d]: got %b, required %b", i, o_busy, (i < 2));
      end
      checks++;
      if (o_res_val !== (i == 2)) begin
        errors++;
        $display("FAIL basic_val[%0d]: got %b, required %b", i, o_res_val, (i == 2));
      end
    end
    cycle();
    checks++;
    if (o_res_val !== 1'b0) begin
      errors++;
      $display("FAIL basic_val_width: got %b, required 0", o_res_val);
    end
    drain("basic");
  endtask

  task automatic test_saturation();
    cfg_len = 12'd4;
    expect_res(8'd255, 1'b1);
    repeat (4) drive(8'd100);
    cycle();
    cfg_len = 12'd2;
    expect_res(8'd255, 1'b0);
    drive(8'd200);
    drive(8'd55);
    drain("saturation");
  endtask

  task automatic test_gaps_len();
    cfg_len = 12'd0;
    expect_res(8'd7, 1'b0);
    expect_res(8'd9, 1'b0);
    drive(8'd7);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_busy: got %b, required 0", o_busy);
    end
    drive(8'd9);
    drain("len0");
    cfg_len = 12'd3;
    expect_res(8'd6, 1'b0);
    drive(8'd1);
    repeat (5) cycle();
    checks++;
    if (o_busy !== 1'b1 || o_res_val !== 1'b0) begin
      errors++;
      $display("FAIL gap_hold: got busy=%b val=%b, required busy=1 val=0", o_busy, o_res_val);
    end
    cfg_len = 12'd1;
    drive(8'd2);
    cycle();
    drive(8'd3);
    drain("gaps");
  endtask

  task automatic test_overflow();
    do_reset();
    cfg_len = 12'd1; i_res_rdy = 1'b0;
    expect_res(8'd1, 1'b0);
    expect_res(8'd2, 1'b0);
    drive(8'd1);
    drive(8'd2);
    drive(8'd3);
    cycle();
    checks++;
    if (o_ovf !== 1'b1 || o_res_val !== 1'b1 || o_res !== 8'd1) begin
      errors++;
      $display("FAIL ovf_full: got ovf=%b val=%b res=%0d, required ovf=1 val=1 res=1", o_ovf, o_res_val, o_res);
    end
    i_res_rdy = 1'b1;
    drain("overflow");
    checks++;
    if (o_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b, required 1", o_ovf);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cfg_len = 12'd1; i_res_rdy = 1'b0;
    expect_res(8'd1, 1'b0);
    expect_res(8'd2, 1'b0);
    expect_res(8'd3, 1'b0);
    drive(8'd1);
    drive(8'd2);
    i_res_rdy = 1'b1;
    drive(8'd3);
    checks++;
    if (o_ovf !== 1'b0 || o_res !== 8'd2) begin
      errors++;
      $display("FAIL full_push_pop: got ovf=%b head=%0d, required ovf=0 head=2", o_ovf, o_res);
    end
    drain("back_to_back");
    checks++;
    if (o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop_ovf: got %b, required 0", o_ovf);
    end
  endtask

  task automatic test_reset_mid();
    cfg_len = 12'd4; i_res_rdy = 1'b1;
    drive(8'd5);
    drive(8'd5);
    rst = 1'b1;
    cycle();
    check_zero_outputs("reset_mid_during");
    rst = 1'b0;
    cycle();
    check_zero_outputs("reset_mid_after");
    expect_res(8'd4, 1'b0);
    repeat (4) drive(8'd1);
    drain("reset_mid");
  endtask

  initial begin
    rst = 1'b1; i_psum_val = 1'b0; i_psum = '0; cfg_len = '0; i_res_rdy = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_gaps_len();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
